// File: rtl/cmsdk_fpga_sram_pkg.sv
// Shared definitions for the two-master FPGA SRAM arbiter: owner encoding and
// the WREN value that marks a read access.
package cmsdk_fpga_sram_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    localparam logic [3:0] WREN_READ = 4'h0;

    function automatic owner_e owner_of(input logic sel);
        return sel ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/cmsdk_fpga_sram_arb2_if.sv
// One SRAM access port as seen by a requesting master: request fields going in,
// grant and read return coming back.
interface cmsdk_fpga_sram_arb2_if #(
    parameter int AW = 16
);
    logic          req;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wren;
    logic          gnt;
    logic          rvalid;
    logic [31:0]   rdata;

    modport master (
        output req, addr, wdata, wren,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, wdata, wren,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/cmsdk_sram_rr_arb2.sv
// Round-robin grant logic for two masters with a burst limit under contention.
//   state    | meaning
//   OWN_IDLE | previous cycle had no grant
//   OWN_M0   | previous cycle granted M0
//   OWN_M1   | previous cycle granted M1
module cmsdk_sram_rr_arb2
    import cmsdk_fpga_sram_pkg::*;
#(
    parameter int MAXBURST = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    localparam int            BW        = $clog2(MAXBURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAXBURST);

    owner_e        r_state;
    owner_e        w_state_nxt;
    logic [BW-1:0] r_burst;
    logic [BW-1:0] w_burst_nxt;
    logic [BW-1:0] w_burst_inc;
    logic          r_last;
    logic          w_last_nxt;
    logic          w_any;
    logic          w_sel;
    logic          w_keep;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= OWN_IDLE;
            r_burst <= '0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_burst <= w_burst_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign w_burst_inc = (r_burst == BURST_MAX) ? BURST_MAX : r_burst + 1'b1;
    assign w_keep      = (r_state != OWN_IDLE) && (r_burst < BURST_MAX);

    always_comb begin
        w_any       = 1'b0;
        w_sel       = 1'b0;
        w_state_nxt = OWN_IDLE;
        w_burst_nxt = r_burst;
        w_last_nxt  = r_last;
        case (i_req)
            2'b01: begin
                w_any = 1'b1;
                w_sel = 1'b0;
            end
            2'b10: begin
                w_any = 1'b1;
                w_sel = 1'b1;
            end
            2'b11: begin
                w_any = 1'b1;
                // the last pointer starts at M1, so M0 wins the first tie
                w_sel = w_keep ? (r_state == OWN_M1) : ~r_last;
            end
            default: begin
                w_any = 1'b0;
            end
        endcase
        if (w_any) begin
            w_state_nxt = owner_of(w_sel);
            w_last_nxt  = w_sel;
            w_burst_nxt = (r_state == w_state_nxt) ? w_burst_inc : BW'(1);
        end
    end

    assign o_gnt = (w_any && !i_rst) ? {w_sel, ~w_sel} : 2'b00;

endmodule

// File: rtl/cmsdk_fpga_sram_arb2.sv
// Shares a single-port block-RAM between two masters: address/data steering to
// the SRAM and one-cycle read return to whichever master owned the read.
module cmsdk_fpga_sram_arb2
    import cmsdk_fpga_sram_pkg::*;
#(
    parameter int AW       = 16,
    parameter int MAXBURST = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    cmsdk_fpga_sram_arb2_if.slave    m0,
    cmsdk_fpga_sram_arb2_if.slave    m1,
    output logic [AW-1:0]            SRAM_ADDR,
    output logic [31:0]              SRAM_WDATA,
    output logic [3:0]               SRAM_WREN,
    output logic                     SRAM_CS,
    input  logic [31:0]              SRAM_RDATA
);
    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       r_rd_pend0;
    logic       r_rd_pend1;

    assign w_req = {m1.req, m0.req};

    cmsdk_sram_rr_arb2 #(
        .MAXBURST (MAXBURST)
    ) u_arb (
        .i_clk (CLK),
        .i_rst (RESET),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    always_comb begin
        SRAM_ADDR  = '0;
        SRAM_WDATA = '0;
        SRAM_WREN  = '0;
        if (w_gnt[0]) begin
            SRAM_ADDR  = m0.addr;
            SRAM_WDATA = m0.wdata;
            SRAM_WREN  = m0.wren;
        end else if (w_gnt[1]) begin
            SRAM_ADDR  = m1.addr;
            SRAM_WDATA = m1.wdata;
            SRAM_WREN  = m1.wren;
        end
    end

    assign SRAM_CS = |w_gnt;

    // The SRAM registers its address, so a read only needs its owner remembered for one cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd_pend0 <= 1'b0;
            r_rd_pend1 <= 1'b0;
        end else begin
            r_rd_pend0 <= w_gnt[0] && (m0.wren == WREN_READ);
            r_rd_pend1 <= w_gnt[1] && (m1.wren == WREN_READ);
        end
    end

    assign m0.gnt    = w_gnt[0];
    assign m1.gnt    = w_gnt[1];
    assign m0.rvalid = r_rd_pend0;
    assign m1.rvalid = r_rd_pend1;
    assign m0.rdata  = r_rd_pend0 ? SRAM_RDATA : '0;
    assign m1.rdata  = r_rd_pend1 ? SRAM_RDATA : '0;

endmodule

// File: tb/tb_cmsdk_fpga_sram_arb2.sv
// Directed bench for the two-master SRAM arbiter with a behavioural 1-cycle block-RAM.
module tb_cmsdk_fpga_sram_arb2;

    logic        clk;
    logic        rst;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_wren;
    logic        sram_cs;
    logic [31:0] sram_rdata;
    logic [31:0] mem [0:255];

    int n_checks;
    int n_errors;

    cmsdk_fpga_sram_arb2_if #(.AW(16)) m0_if ();
    cmsdk_fpga_sram_arb2_if #(.AW(16)) m1_if ();

    cmsdk_fpga_sram_arb2 #(
        .AW       (16),
        .MAXBURST (4)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .m0         (m0_if),
        .m1         (m1_if),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WDATA (sram_wdata),
        .SRAM_WREN  (sram_wren),
        .SRAM_CS    (sram_cs),
        .SRAM_RDATA (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_wren == 4'h0) begin
                sram_rdata <= mem[sram_addr[7:0]];
            end else begin
                if (sram_wren[0]) mem[sram_addr[7:0]][7:0]   <= sram_wdata[7:0];
                if (sram_wren[1]) mem[sram_addr[7:0]][15:8]  <= sram_wdata[15:8];
                if (sram_wren[2]) mem[sram_addr[7:0]][23:16] <= sram_wdata[23:16];
                if (sram_wren[3]) mem[sram_addr[7:0]][31:24] <= sram_wdata[31:24];
            end
        end
    end

    task automatic clear_reqs;
        m0_if.req = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.wren = '0;
        m1_if.req = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.wren = '0;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        m0_if.req = 1'b1;
        m1_if.req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if ({m1_if.gnt, m0_if.gnt} !== 2'b00) begin
            n_errors++; $display("FAIL reset_gnt: got %b, expected 00", {m1_if.gnt, m0_if.gnt});
        end
        n_checks++;
        if (sram_cs !== 1'b0) begin
            n_errors++; $display("FAIL reset_cs: got %b, expected 0", sram_cs);
        end
        n_checks++;
        if ({m1_if.rvalid, m0_if.rvalid} !== 2'b00) begin
            n_errors++; $display("FAIL reset_rvalid: got %b, expected 00", {m1_if.rvalid, m0_if.rvalid});
        end
        n_checks++;
        if ((m0_if.rdata | m1_if.rdata) !== 32'h0) begin
            n_errors++; $display("FAIL reset_rdata: got %h/%h, expected 0", m0_if.rdata, m1_if.rdata);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({m1_if.gnt, m0_if.gnt} !== 2'b01) begin
            n_errors++; $display("FAIL reset_first_tie: got %b, expected 01", {m1_if.gnt, m0_if.gnt});
        end
        clear_reqs();
        next_cycle();
    endtask

    task automatic test_write_read;
        m0_if.req = 1'b1; m0_if.addr = 16'h0010; m0_if.wdata = 32'hDEADBEEF; m0_if.wren = 4'hF;
        #1;
        n_checks++;
        if ({m1_if.gnt, m0_if.gnt, sram_cs} !== 3'b011) begin
            n_errors++; $display("FAIL wr_gnt_cs: got %b, expected 011", {m1_if.gnt, m0_if.gnt, sram_cs});
        end
        n_checks++;
        if ({sram_addr, sram_wdata, sram_wren} !== {16'h0010, 32'hDEADBEEF, 4'hF}) begin
            n_errors++; $display("FAIL wr_steer: got %h %h %h, expected 0010 deadbeef f", sram_addr, sram_wdata, sram_wren);
        end
        next_cycle();
        n_checks++;
        if (m0_if.rvalid !== 1'b0) begin
            n_errors++; $display("FAIL wr_no_rvalid: got %b, expected 0", m0_if.rvalid);
        end
        m0_if.wren = 4'h0; m0_if.wdata = '0;
        #1;
        n_checks++;
        if ({m0_if.gnt, sram_wren} !== {1'b1, 4'h0}) begin
            n_errors++; $display("FAIL rd_gnt: got %b %h, expected 1 0", m0_if.gnt, sram_wren);
        end
        next_cycle();
        clear_reqs();
        n_checks++;
        if (m0_if.rvalid !== 1'b1) begin
            n_errors++; $display("FAIL rd_rvalid: got %b, expected 1", m0_if.rvalid);
        end
        n_checks++;
        if (m0_if.rdata !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL rd_rdata: got %h, expected deadbeef", m0_if.rdata);
        end
        n_checks++;
        if ({m1_if.rvalid, m1_if.rdata} !== 33'h0) begin
            n_errors++; $display("FAIL rd_m1_quiet: got %b %h, expected 0 0", m1_if.rvalid, m1_if.rdata);
        end
        next_cycle();
        n_checks++;
        if ({m0_if.rvalid, m0_if.rdata} !== 33'h0) begin
            n_errors++; $display("FAIL rd_single: got %b %h, expected 0 0", m0_if.rvalid, m0_if.rdata);
        end
    endtask

    task automatic test_m1_only;
        m1_if.req = 1'b1; m1_if.addr = 16'h0040; m1_if.wren = 4'h0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if ({m1_if.gnt, m0_if.gnt} !== 2'b10) begin
                n_errors++; $display("FAIL m1_only_gnt[%0d]: got %b, expected 10", i, {m1_if.gnt, m0_if.gnt});
            end
            next_cycle();
            n_checks++;
            if ({m1_if.rvalid, m0_if.rvalid} !== 2'b10) begin
                n_errors++; $display("FAIL m1_only_rvalid[%0d]: got %b, expected 10", i, {m1_if.rvalid, m0_if.rvalid});
            end
        end
        clear_reqs();
        next_cycle();
    endtask

    task automatic test_contention;
        logic exp_sel;
        logic prev_sel;
        prev_sel = 1'b0;
        m0_if.req = 1'b1; m0_if.addr = 16'h0020;
        m1_if.req = 1'b1; m1_if.addr = 16'h0030;
        for (int i = 0; i < 12; i++) begin
            #1;
            exp_sel = (((i / 4) % 2) == 1);
            n_checks++;
            if ({m1_if.gnt, m0_if.gnt} !== {exp_sel, ~exp_sel}) begin
                n_errors++; $display("FAIL burst_gnt[%0d]: got %b, expected %b", i, {m1_if.gnt, m0_if.gnt}, {exp_sel, ~exp_sel});
            end
            if (i > 0) begin
                n_checks++;
                if ({m1_if.rvalid, m0_if.rvalid} !== {prev_sel, ~prev_sel}) begin
                    n_errors++; $display("FAIL burst_rvalid[%0d]: got %b, expected %b", i, {m1_if.rvalid, m0_if.rvalid}, {prev_sel, ~prev_sel});
                end
            end
            prev_sel = exp_sel;
            next_cycle();
        end
        clear_reqs();
        next_cycle();
    endtask

    task automatic test_partial_write;
        m1_if.req = 1'b1; m1_if.addr = 16'h0050; m1_if.wdata = 32'h11223344; m1_if.wren = 4'hF;
        next_cycle();
        m1_if.wdata = 32'h0000AB00; m1_if.wren = 4'b0010;
        #1;
        n_checks++;
        if ({m1_if.gnt, sram_wren} !== {1'b1, 4'b0010}) begin
            n_errors++; $display("FAIL partial_gnt: got %b %b, expected 1 0010", m1_if.gnt, sram_wren);
        end
        next_cycle();
        m1_if.wdata = '0; m1_if.wren = 4'h0;
        next_cycle();
        clear_reqs();
        n_checks++;
        if ({m1_if.rvalid, m1_if.rdata} !== {1'b1, 32'h1122AB44}) begin
            n_errors++; $display("FAIL partial_rdata: got %b %h, expected 1 1122ab44", m1_if.rvalid, m1_if.rdata);
        end
        n_checks++;
        if ({m0_if.rvalid, m0_if.rdata} !== 33'h0) begin
            n_errors++; $display("FAIL partial_m0_quiet: got %b %h, expected 0 0", m0_if.rvalid, m0_if.rdata);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back;
        m0_if.req = 1'b1; m0_if.addr = 16'h0010; m0_if.wren = 4'h0;
        next_cycle();
        m0_if.req = 1'b0; m0_if.addr = '0;
        m1_if.req = 1'b1; m1_if.addr = 16'h0010; m1_if.wdata = 32'h12345678; m1_if.wren = 4'hF;
        #1;
        n_checks++;
        if ({m1_if.gnt, m0_if.gnt, sram_addr} !== {2'b10, 16'h0010}) begin
            n_errors++; $display("FAIL b2b_gnt: got %b %h, expected 10 0010", {m1_if.gnt, m0_if.gnt}, sram_addr);
        end
        n_checks++;
        if ({m0_if.rvalid, m0_if.rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_errors++; $display("FAIL b2b_rdata: got %b %h, expected 1 deadbeef", m0_if.rvalid, m0_if.rdata);
        end
        next_cycle();
        clear_reqs();
        n_checks++;
        if ({m1_if.rvalid, m0_if.rvalid} !== 2'b00) begin
            n_errors++; $display("FAIL b2b_after: got %b, expected 00", {m1_if.rvalid, m0_if.rvalid});
        end
        next_cycle();
    endtask

    task automatic test_reset_read;
        m0_if.req = 1'b1; m0_if.addr = 16'h0010; m0_if.wren = 4'h0;
        #1;
        n_checks++;
        if (m0_if.gnt !== 1'b1) begin
            n_errors++; $display("FAIL rstrd_gnt: got %b, expected 1", m0_if.gnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({m0_if.gnt, sram_cs} !== 2'b00) begin
            n_errors++; $display("FAIL rstrd_gnt_in_reset: got %b, expected 00", {m0_if.gnt, sram_cs});
        end
        clear_reqs();
        @(negedge clk);
        n_checks++;
        if ({m0_if.rvalid, m0_if.rdata} !== 33'h0) begin
            n_errors++; $display("FAIL rstrd_no_rvalid: got %b %h, expected 0 0", m0_if.rvalid, m0_if.rdata);
        end
        m0_if.req = 1'b1;
        m1_if.req = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({m1_if.gnt, m0_if.gnt} !== 2'b01) begin
            n_errors++; $display("FAIL rstrd_restart: got %b, expected 01", {m1_if.gnt, m0_if.gnt});
        end
        clear_reqs();
        next_cycle();
        n_checks++;
        if ({m1_if.rvalid, m0_if.rvalid} !== 2'b00) begin
            n_errors++; $display("FAIL rstrd_quiet: got %b, expected 00", {m1_if.rvalid, m0_if.rvalid});
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        sram_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b1;
        clear_reqs();
        test_reset();
        test_write_read();
        test_m1_only();
        test_contention();
        test_partial_write();
        test_back_to_back();
        test_reset_read();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
